// File: rtl/retire_ctrl.sv
// -----------------------------------------------------------------------------
// retire_ctrl
//
// Multi-way in-order commit controller sitting between the ROB head and the
// free list, architectural map table, store queue and load queue. Each cycle
// it looks at the WAY oldest ROB entries and decides how many retire. The
// retirement path is purely combinational from head_* to the outputs. A small
// RUN/FLUSH/HALTED state machine and two performance counters sit alongside.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   head_*              per-slot ROB head information, slot 0 is oldest
//   sq_grant            number of offered stores the SQ accepts this cycle
//   retire_num          entries popped from the ROB this cycle
//   free_valid/_Told    old physical registers returned to the free list
//   amt_we/_arch/_T     architectural map table writes (younger slot wins)
//   sq_req              number of stores offered to the SQ this cycle
//   lq_retire           per-slot load retire mask
//   flush               registered one-cycle pipeline flush pulse
//   halted              sticky halt indication, cleared only by reset
//   retired_cnt         total retired instructions (wraps)
//   store_stall_cnt     cycles a ready store was held back by the SQ (saturates)
// -----------------------------------------------------------------------------
module retire_ctrl #(
   parameter  int WAY         = 3,
   parameter  int STORE_PORTS = 1,
   parameter  int PHY_IDX_W   = 6,
   parameter  int ARCH_IDX_W  = 5,
   parameter  int CNT_W       = 32,
   localparam int RN_W        = $clog2(WAY + 1),
   localparam int SQ_W        = $clog2(STORE_PORTS + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [WAY-1:0]            head_valid,
   input  logic [WAY-1:0]            head_complete,
   input  logic [WAY-1:0]            head_is_store,
   input  logic [WAY-1:0]            head_is_load,
   input  logic [WAY-1:0]            head_has_dest,
   input  logic [WAY-1:0]            head_mispredict,
   input  logic [WAY-1:0]            head_halt,
   input  logic [WAY*PHY_IDX_W-1:0]  head_T,
   input  logic [WAY*PHY_IDX_W-1:0]  head_Told,
   input  logic [WAY*ARCH_IDX_W-1:0] head_arch_dest,
   input  logic [SQ_W-1:0]           sq_grant,
   output logic [RN_W-1:0]           retire_num,
   output logic [WAY-1:0]            free_valid,
   output logic [WAY*PHY_IDX_W-1:0]  free_Told,
   output logic [WAY-1:0]            amt_we,
   output logic [WAY*ARCH_IDX_W-1:0] amt_arch,
   output logic [WAY*PHY_IDX_W-1:0]  amt_T,
   output logic [SQ_W-1:0]           sq_req,
   output logic [WAY-1:0]            lq_retire,
   output logic                      flush,
   output logic                      halted,
   output logic [CNT_W-1:0]          retired_cnt,
   output logic [CNT_W-1:0]          store_stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_HALTED
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [WAY-1:0]   slot_ready;
   logic [RN_W-1:0]  cand_len;
   logic [SQ_W-1:0]  cand_stores;
   logic             cand_stop;
   logic [RN_W-1:0]  commit_len;
   logic [SQ_W-1:0]  commit_seen;
   logic             commit_stop;
   logic [WAY-1:0]   commit_mask;
   logic             run_en;
   logic             halt_hit;
   logic             mp_hit;
   logic             stall_event;

   // Retirement only happens in RUN and never while reset is held low.
   assign run_en     = (state_q == ST_RUN) && reset;
   assign slot_ready = head_valid & head_complete;

   // Candidate prefix: oldest-first run of finished slots. It stops in front
   // of a store the SQ could never take this cycle, and stops just after the
   // first mispredict/halt so nothing younger than a redirect retires.
   // NOTE: every variable written in an always_comb gets a default at the top
   // so no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cand_len    = '0;
      cand_stores = '0;
      cand_stop   = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         if (!cand_stop) begin
            if (!slot_ready[i]) begin
               cand_stop = 1'b1;
            end else if (head_is_store[i] && (int'(cand_stores) == STORE_PORTS)) begin
               cand_stop = 1'b1;
            end else begin
               cand_len = RN_W'(i + 1);
               if (head_is_store[i]) begin
                  cand_stores = cand_stores + SQ_W'(1);
               end
               if (head_mispredict[i] || head_halt[i]) begin
                  cand_stop = 1'b1;
               end
            end
         end
      end
   end

   // Commit group: the candidate prefix cut just before the first store the
   // SQ did not grant. Older non-store slots ahead of that store still go.
   always_comb begin
      commit_len  = '0;
      commit_seen = '0;
      commit_stop = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         if (!commit_stop && (i < int'(cand_len))) begin
            if (head_is_store[i] && (commit_seen == sq_grant)) begin
               commit_stop = 1'b1;
            end else begin
               commit_len = RN_W'(i + 1);
               if (head_is_store[i]) begin
                  commit_seen = commit_seen + SQ_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      commit_mask = '0;
      for (int i = 0; i < WAY; i++) begin
         commit_mask[i] = run_en && (i < int'(commit_len));
      end
   end

   assign retire_num = run_en ? commit_len  : '0;
   assign sq_req     = run_en ? cand_stores : '0;
   assign free_valid = commit_mask & head_has_dest;
   assign amt_we     = commit_mask & head_has_dest;
   assign lq_retire  = commit_mask & head_is_load;

   // Index/value buses pass straight through; the enables qualify them. When
   // two retiring slots share an arch dest, the map table applies slots in
   // order so the younger (higher) slot's T is the one that sticks.
   assign free_Told  = head_Told;
   assign amt_arch   = head_arch_dest;
   assign amt_T      = head_T;

   // A redirect only counts if its slot actually commits; one stuck behind an
   // ungranted store is ignored and will be seen again next cycle.
   assign halt_hit    = |(commit_mask & head_halt);
   assign mp_hit      = |(commit_mask & head_mispredict);
   assign stall_event = (sq_req > sq_grant);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (halt_hit) begin
               state_d = ST_HALTED;
            end else if (mp_hit) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH:  state_d = ST_RUN;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_comb begin
      retired_cnt_d = retired_cnt_q + CNT_W'(retire_num);
      stall_cnt_d   = stall_cnt_q;
      if (stall_event && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value; reset is synchronous, so it is only seen at an edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         retired_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         retired_cnt_q <= retired_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   // Flush and halted decode straight from the state register, so both are
   // glitch-free registered signals.
   assign flush           = (state_q == ST_FLUSH);
   assign halted          = (state_q == ST_HALTED);
   assign retired_cnt     = retired_cnt_q;
   assign store_stall_cnt = stall_cnt_q;

   // The SQ may never accept more stores than were offered.
   always_ff @(posedge clock) begin
      if (reset) begin
         assert (sq_grant <= sq_req);
      end
   end

endmodule

// File: tb/tb_retire_ctrl.sv
// -----------------------------------------------------------------------------
// tb_retire_ctrl
//
// Directed bench for retire_ctrl with default parameters (WAY=3,
// STORE_PORTS=1). The driver applies one vector per cycle just after the
// rising edge and pushes the hand-computed expected response; a separate
// monitor pops and compares at every falling edge.
// -----------------------------------------------------------------------------
module tb_retire_ctrl;

   localparam int WAY  = 3;
   localparam int PW   = 6;
   localparam int AW   = 5;
   localparam int CW   = 32;
   localparam int RN_W = 2;
   localparam int SQ_W = 1;

   typedef struct {
      logic [WAY-1:0]    valid;
      logic [WAY-1:0]    complete;
      logic [WAY-1:0]    store;
      logic [WAY-1:0]    load;
      logic [WAY-1:0]    dest;
      logic [WAY-1:0]    mp;
      logic [WAY-1:0]    halt;
      logic [WAY*PW-1:0] t;
      logic [WAY*PW-1:0] told;
      logic [WAY*AW-1:0] arch;
      logic [SQ_W-1:0]   grant;
      logic              rst_n;
   } vec_t;

   typedef struct {
      logic [RN_W-1:0]   rn;
      logic [WAY-1:0]    fv;
      logic [WAY-1:0]    we;
      logic [WAY-1:0]    lq;
      logic [SQ_W-1:0]   sq;
      logic              fl;
      logic              ha;
      logic [CW-1:0]     rcnt;
      logic [CW-1:0]     scnt;
      logic [WAY*PW-1:0] told;
      logic [WAY*PW-1:0] t;
      logic [WAY*AW-1:0] arch;
   } exp_t;

   logic                clock = 1'b0;
   logic                reset;
   logic [WAY-1:0]      head_valid, head_complete, head_is_store, head_is_load;
   logic [WAY-1:0]      head_has_dest, head_mispredict, head_halt;
   logic [WAY*PW-1:0]   head_T, head_Told;
   logic [WAY*AW-1:0]   head_arch_dest;
   logic [SQ_W-1:0]     sq_grant;
   logic [RN_W-1:0]     retire_num;
   logic [WAY-1:0]      free_valid, amt_we, lq_retire;
   logic [WAY*PW-1:0]   free_Told, amt_T;
   logic [WAY*AW-1:0]   amt_arch;
   logic [SQ_W-1:0]     sq_req;
   logic                flush, halted;
   logic [CW-1:0]       retired_cnt, store_stall_cnt;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   mon_idx = 0;

   always #5 clock = ~clock;

   retire_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .head_valid      (head_valid),
      .head_complete   (head_complete),
      .head_is_store   (head_is_store),
      .head_is_load    (head_is_load),
      .head_has_dest   (head_has_dest),
      .head_mispredict (head_mispredict),
      .head_halt       (head_halt),
      .head_T          (head_T),
      .head_Told       (head_Told),
      .head_arch_dest  (head_arch_dest),
      .sq_grant        (sq_grant),
      .retire_num      (retire_num),
      .free_valid      (free_valid),
      .free_Told       (free_Told),
      .amt_we          (amt_we),
      .amt_arch        (amt_arch),
      .amt_T           (amt_T),
      .sq_req          (sq_req),
      .lq_retire       (lq_retire),
      .flush           (flush),
      .halted          (halted),
      .retired_cnt     (retired_cnt),
      .store_stall_cnt (store_stall_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL step%0d %s: got %0h want %0h", mon_idx, name, act, req);
      end
   endtask

   function automatic logic [WAY*PW-1:0] mask_pw(input logic [WAY-1:0] en);
      logic [WAY*PW-1:0] m;
      m = '0;
      for (int i = 0; i < WAY; i++) m[i*PW +: PW] = {PW{en[i]}};
      return m;
   endfunction

   function automatic logic [WAY*AW-1:0] mask_aw(input logic [WAY-1:0] en);
      logic [WAY*AW-1:0] m;
      m = '0;
      for (int i = 0; i < WAY; i++) m[i*AW +: AW] = {AW{en[i]}};
      return m;
   endfunction

   function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] complete,
                               input logic [2:0] store, input logic [2:0] load,
                               input logic [2:0] dest, input logic [2:0] mp,
                               input logic [2:0] halt, input logic grant,
                               input logic rst_n);
      vec_t v;
      v.valid = valid;  v.complete = complete; v.store = store; v.load = load;
      v.dest  = dest;   v.mp = mp;             v.halt = halt;
      v.t     = {6'd12, 6'd11, 6'd10};
      v.told  = {6'd3, 6'd2, 6'd1};
      v.arch  = {5'd3, 5'd2, 5'd1};
      v.grant = grant;
      v.rst_n = rst_n;
      return v;
   endfunction

   function automatic exp_t ex(input logic [1:0] rn, input logic [2:0] fv,
                               input logic [2:0] we, input logic [2:0] lq,
                               input logic sq, input logic fl, input logic ha,
                               input logic [31:0] rcnt, input logic [31:0] scnt);
      exp_t e;
      e.rn = rn; e.fv = fv; e.we = we; e.lq = lq; e.sq = sq;
      e.fl = fl; e.ha = ha; e.rcnt = rcnt; e.scnt = scnt;
      e.told = '0; e.t = '0; e.arch = '0;
      return e;
   endfunction

   // Apply one vector after the rising edge; the expected pass-through values
   // are the indices the bench itself chose for this vector.
   task automatic step(input vec_t v, input exp_t e);
      @(posedge clock);
      #1;
      reset           = v.rst_n;
      head_valid      = v.valid;
      head_complete   = v.complete;
      head_is_store   = v.store;
      head_is_load    = v.load;
      head_has_dest   = v.dest;
      head_mispredict = v.mp;
      head_halt       = v.halt;
      head_T          = v.t;
      head_Told       = v.told;
      head_arch_dest  = v.arch;
      sq_grant        = v.grant;
      e.told = v.told;
      e.t    = v.t;
      e.arch = v.arch;
      exp_q.push_back(e);
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the oldest
   // outstanding expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_idx++;
            check("retire_num",      64'(retire_num),      64'(mon_e.rn));
            check("free_valid",      64'(free_valid),      64'(mon_e.fv));
            check("amt_we",          64'(amt_we),          64'(mon_e.we));
            check("lq_retire",       64'(lq_retire),       64'(mon_e.lq));
            check("sq_req",          64'(sq_req),          64'(mon_e.sq));
            check("flush",           64'(flush),           64'(mon_e.fl));
            check("halted",          64'(halted),          64'(mon_e.ha));
            check("retired_cnt",     64'(retired_cnt),     64'(mon_e.rcnt));
            check("store_stall_cnt", 64'(store_stall_cnt), 64'(mon_e.scnt));
            if (mon_e.fv != '0) begin
               check("free_Told", 64'(free_Told & mask_pw(mon_e.fv)),
                     64'(mon_e.told & mask_pw(mon_e.fv)));
            end
            if (mon_e.we != '0) begin
               check("amt_T",    64'(amt_T & mask_pw(mon_e.we)),
                     64'(mon_e.t & mask_pw(mon_e.we)));
               check("amt_arch", 64'(amt_arch & mask_aw(mon_e.we)),
                     64'(mon_e.arch & mask_aw(mon_e.we)));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v_all, v_empty, v;

      reset = 1'b0;
      head_valid = '0; head_complete = '0; head_is_store = '0; head_is_load = '0;
      head_has_dest = '0; head_mispredict = '0; head_halt = '0;
      head_T = '0; head_Told = '0; head_arch_dest = '0; sq_grant = '0;

      v_all   = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1);
      v_empty = mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

      // Reset held: everything quiet.
      v = v_all; v.rst_n = 1'b0;
      step(v, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      step(v, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0));

      // Full-width retire, T={10,11,12}, Told={1,2,3}.
      step(v_all,   ex(3, 3'b111, 3'b111, 3'b000, 0, 0, 0, 0, 0));
      step(v_empty, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3, 0));

      // Stores in slots 0 and 2, one SQ port, granted: slot 2 waits.
      step(mk(3'b111, 3'b111, 3'b101, 3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1),
           ex(2, 3'b010, 3'b010, 3'b010, 1, 0, 0, 3, 0));
      // Lone store with no grant: nothing retires, stall counted.
      step(mk(3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1),
           ex(0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 5, 0));
      step(v_empty, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 5, 1));

      // Mispredict in slot 1 truncates after it; one FLUSH cycle follows.
      step(mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b010, 3'b000, 1'b0, 1'b1),
           ex(2, 3'b011, 3'b011, 3'b000, 0, 0, 0, 5, 1));
      step(v_all, ex(0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 7, 1));
      step(v_all, ex(3, 3'b111, 3'b111, 3'b000, 0, 0, 0, 7, 1));

      // Oldest slot incomplete blocks younger completed slots.
      step(mk(3'b111, 3'b110, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1),
           ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 10, 1));

      // Two slots writing arch 5: both enables, slot 1 carries T=21.
      v = mk(3'b011, 3'b011, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0, 1'b1);
      v.arch = {5'd0, 5'd5, 5'd5};
      v.t    = {6'd0, 6'd21, 6'd20};
      step(v, ex(2, 3'b011, 3'b011, 3'b000, 0, 0, 0, 10, 1));

      // Mispredict behind an ungranted store does not flush.
      step(mk(3'b111, 3'b111, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 1'b0, 1'b1),
           ex(0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 12, 1));
      step(v_empty, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 12, 2));

      // Slot 0 halt (with mispredict as well): halt wins, then sticky HALTED.
      step(mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 1'b0, 1'b1),
           ex(1, 3'b001, 3'b001, 3'b000, 0, 0, 0, 12, 2));
      for (int k = 0; k < 10; k++) begin
         step(v_all, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 13, 2));
      end

      // Reset low: outputs gated at once, state clears at the next edge.
      v = v_all; v.rst_n = 1'b0;
      step(v, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 13, 2));
      step(v, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      step(v_all,   ex(3, 3'b111, 3'b111, 3'b000, 0, 0, 0, 0, 0));
      step(v_empty, ex(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3, 0));

      @(negedge clock);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/retire_ctrl.md
Name: retire_ctrl

Overview:
- Multi-way commit controller between the ROB head and the free list, arch map table, store queue and load queue.
- Each cycle it picks how many of the oldest WAY ROB entries retire. Stores commit to the SQ through a multi-port grant handshake.
- A retiring mispredict or halt truncates the retire group. A FLUSH/HALTED FSM and performance counters are kept alongside.

Parameters:
- WAY, 3, retire width (ROB head slots examined per cycle)
- STORE_PORTS, 1, max stores committed to SQ per cycle (1..WAY)
- PHY_IDX_W, 6, physical register index width
- ARCH_IDX_W, 5, architectural register index width
- CNT_W, 32, width of performance counters

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- head_valid  in  WAY  slot i holds an instruction; slot 0 is oldest
- head_complete  in  WAY  slot i finished execution
- head_is_store  in  WAY  slot i is a store
- head_is_load  in  WAY  slot i is a load
- head_has_dest  in  WAY  slot i writes a register
- head_mispredict  in  WAY  slot i is a mispredicted branch
- head_halt  in  WAY  slot i is a halt
- head_T  in  WAY*PHY_IDX_W  new physical dest per slot
- head_Told  in  WAY*PHY_IDX_W  previous physical dest per slot
- head_arch_dest  in  WAY*ARCH_IDX_W  architectural dest per slot
- sq_grant  in  $clog2(STORE_PORTS+1)  stores SQ accepts this cycle (≤ sq_req)
- retire_num  out  $clog2(WAY+1)  entries popped from ROB this cycle
- free_valid  out  WAY  Told[i] returned to free list
- free_Told  out  WAY*PHY_IDX_W  pass-through of head_Told
- amt_we  out  WAY  arch map write enable per slot
- amt_arch  out  WAY*ARCH_IDX_W  arch map write index
- amt_T  out  WAY*PHY_IDX_W  arch map write value
- sq_req  out  $clog2(STORE_PORTS+1)  stores offered to SQ this cycle
- lq_retire  out  WAY  per-slot load retire mask
- flush  out  1  registered pipeline flush pulse
- halted  out  1  sticky halt indication
- retired_cnt  out  CNT_W  total retired instructions
- store_stall_cnt  out  CNT_W  cycles a ready store was blocked by SQ

Behaviour:
- FSM states:
  - RUN: normal retirement.
  - FLUSH: one cycle; retire_num=0; flush=1; returns to RUN.
  - HALTED: retire_num=0; halted=1; exits only on reset.
- Reset (reset==0 at posedge): state=RUN, flush=0, halted=0, both counters=0.
- Combinational outputs (retire_num, free_valid, amt_we, lq_retire, sq_req) are 0 in FLUSH/HALTED and while reset==0.
- Candidate prefix in RUN: the longest run from slot 0 with head_valid&head_complete. It stops before the (STORE_PORTS+1)th store and stops after (inclusive of) the first slot with mispredict or halt.
- sq_req = number of stores in the candidate prefix.
- Commit: the candidate prefix truncated immediately before store number sq_grant+1. Slots before that store still retire.
  - sq_grant > sq_req is illegal; assert in simulation.
- retire_num = commit length. All per-slot outputs are meaningful only for slots < retire_num; other slots are 0.
  - free_valid[i] = amt_we[i] = head_has_dest[i].
  - lq_retire[i] = head_is_load[i].
- Same-cycle retirement of two slots with equal arch_dest: both amt_we asserted; map table priority goes to the higher slot (younger). Both Told freed.
- Retirement path is zero-latency, combinational from head_* to outputs.
- State transitions at the next edge:
  - If the commit includes a halt slot: go to HALTED. Halt takes priority over a mispredict in the same group.
  - Otherwise, if the commit includes a mispredict: go to FLUSH, so flush is high the following cycle.
  - A mispredict/halt slot blocked by an earlier ungranted store does not trigger.
- retired_cnt += retire_num each RUN cycle; wraps modulo 2^CNT_W.
- store_stall_cnt += 1 when sq_req > sq_grant; saturates at all-ones.
- Empty ROB (head_valid=0): retire_num=0, no state change.

Test Plan:
- WAY=3, all three slots valid+complete, has_dest=1, no stores, T={10,11,12}, Told={1,2,3} -> retire_num=3; free_Told {1,2,3} valid; retired_cnt=3 next cycle.
- Slots 0,2 stores, STORE_PORTS=1, all complete, sq_grant=1 -> sq_req=1, retire_num=2, store_stall_cnt unchanged. Next cycle slot 0 store with sq_grant=0 -> retire_num=0, store_stall_cnt=1.
- Slot 1 mispredict, slot 2 valid+complete -> retire_num=2, flush=1 on the next cycle only, retire_num=0 during FLUSH, back to RUN after.
- Slot 0 halt -> retire_num=1, halted=1 from the next cycle and held for 10 cycles regardless of head_*. reset=0 -> halted=0, counters=0.
- Slot 0 incomplete, slots 1-2 complete -> retire_num=0 (in-order).
- Slots 0,1 both arch_dest=5, T={20,21} -> amt_we=2'b11, final map entry 5=21.
